// File: rtl/fx_param_sequencer_pkg.sv
// Shared types and constants for the effects control plane.
// The gain word is Q7.4, so 1.0 is 16.
package fx_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RAMP,
        FADE_OUT,
        HOLD,
        FADE_IN
    } fx_seq_state_t;

    localparam int unsigned GAIN_W    = 11;
    localparam int unsigned GAIN_FRAC = 4;
    localparam int unsigned GAIN_ONE  = 16;

endpackage

// File: rtl/fx_param_sequencer_gain_slew.sv
// Combinational saturating step of a parameter toward its target.
// Moves by at most `step` and never passes the target or wraps.
module gain_slew_step #(
    parameter int unsigned width = 11,
    parameter int unsigned step  = 4
) (
    input  logic [width-1:0] cur,
    input  logic [width-1:0] tgt,
    output logic [width-1:0] nxt
);

    localparam logic [width:0]   step_ext = (width+1)'(step);
    localparam logic [width-1:0] step_w   = width'(step);

    logic [width:0] cur_ext;
    logic [width:0] tgt_ext;
    logic [width:0] up;

    always_comb begin
        cur_ext = {1'b0, cur};
        tgt_ext = {1'b0, tgt};
        up      = cur_ext + step_ext;
        nxt     = cur;
        // Extra headroom bit keeps the up-sum and the down-compare from wrapping.
        if (cur_ext < tgt_ext) begin
            nxt = (up < tgt_ext) ? up[width-1:0] : tgt;
        end else if (cur_ext > tgt_ext) begin
            nxt = (cur_ext > tgt_ext + step_ext) ? (cur - step_w) : tgt;
        end
    end

endmodule

// File: rtl/fx_param_sequencer.sv
// Gain / overdrive-mode sequencer for the effects pipeline: slews gain per tick
// and swaps mode only after fading to zero and letting the pipeline flush.
module fx_param_sequencer
    import fx_ctrl_pkg::*;
#(
    parameter int unsigned gain_width         = GAIN_W,
    parameter int unsigned bits_per_gain_frac = GAIN_FRAC,
    parameter int unsigned ramp_step          = 4,
    parameter int unsigned reset_gain         = 1 << bits_per_gain_frac,
    parameter int unsigned settle_samples     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_tick,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [gain_width-1:0] i_req_gain,
    input  logic                  i_req_mode,
    output logic [gain_width-1:0] o_par_gain,
    output logic                  o_ovrd_mode,
    output logic                  o_busy
);

    localparam int unsigned cnt_w = $clog2(settle_samples + 1);

    fx_seq_state_t         state, state_nxt;
    logic [gain_width-1:0] cur, cur_nxt;
    logic [gain_width-1:0] target, target_nxt;
    logic [gain_width-1:0] pend_gain, pend_gain_nxt;
    logic                  mode, mode_nxt;
    logic                  pend_mode, pend_mode_nxt;
    logic [cnt_w-1:0]      cnt, cnt_nxt;
    logic [gain_width-1:0] step_tgt;
    logic [gain_width-1:0] stepped;
    logic                  accept;

    gain_slew_step #(
        .width (gain_width),
        .step  (ramp_step)
    ) u_slew (
        .cur (cur),
        .tgt (step_tgt),
        .nxt (stepped)
    );

    assign step_tgt    = (state == FADE_OUT) ? '0 : target;
    assign o_par_gain  = cur;
    assign o_ovrd_mode = mode;

    always_comb begin
        state_nxt     = state;
        cur_nxt       = cur;
        target_nxt    = target;
        pend_gain_nxt = pend_gain;
        mode_nxt      = mode;
        pend_mode_nxt = pend_mode;
        cnt_nxt       = cnt;
        o_req_ready   = (state == IDLE) || (state == RAMP);
        o_busy        = (state != IDLE);
        accept        = i_req_valid && o_req_ready;

        case (state)
            IDLE, RAMP: begin
                // A request in the tick cycle takes priority; that tick's step is skipped.
                if (accept) begin
                    if (i_req_mode == mode) begin
                        target_nxt = i_req_gain;
                        state_nxt  = RAMP;
                    end else begin
                        pend_gain_nxt = i_req_gain;
                        pend_mode_nxt = i_req_mode;
                        state_nxt     = FADE_OUT;
                    end
                end else if (state == RAMP) begin
                    if (cur == target) state_nxt = IDLE;
                    if (i_tick)        cur_nxt   = stepped;
                end
            end
            FADE_OUT: begin
                if (cur == '0) begin
                    state_nxt  = HOLD;
                    mode_nxt   = pend_mode;
                    target_nxt = pend_gain;
                    cnt_nxt    = cnt_w'(settle_samples);
                end else if (i_tick) begin
                    cur_nxt = stepped;
                end
            end
            HOLD: begin
                if (cnt == '0)   state_nxt = FADE_IN;
                else if (i_tick) cnt_nxt   = cnt - cnt_w'(1);
            end
            FADE_IN: begin
                if (cur == target) state_nxt = IDLE;
                else if (i_tick)   cur_nxt   = stepped;
            end
            default: state_nxt = FADE_IN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= FADE_IN;
            cur       <= '0;
            target    <= gain_width'(reset_gain);
            pend_gain <= '0;
            mode      <= 1'b0;
            pend_mode <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            cur       <= cur_nxt;
            target    <= target_nxt;
            pend_gain <= pend_gain_nxt;
            mode      <= mode_nxt;
            pend_mode <= pend_mode_nxt;
            cnt       <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fx_param_sequencer.sv
// Bench for fx_param_sequencer: a tick-level plan model predicts gain, mode,
// ready and busy at every sample tick; directed rows plus random requests.
`timescale 1ns/1ps
module tb_fx_param_sequencer;
    import fx_ctrl_pkg::*;

    localparam int STEP   = 4;
    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_tick = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [10:0] i_req_gain = '0;
    logic        i_req_mode = 1'b0;
    logic [10:0] o_par_gain;
    logic        o_ovrd_mode;
    logic        o_busy;

    fx_param_sequencer #(
        .gain_width         (11),
        .bits_per_gain_frac (4),
        .ramp_step          (STEP),
        .reset_gain         (16),
        .settle_samples     (SETTLE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_tick      (i_tick),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_gain  (i_req_gain),
        .i_req_mode  (i_req_mode),
        .o_par_gain  (o_par_gain),
        .o_ovrd_mode (o_ovrd_mode),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    // Expected outputs seen during each upcoming tick cycle.
    typedef struct {
        int gain;
        bit mode;
        bit ready;
        bit busy;
    } exp_t;

    typedef struct {
        int gain;
        bit mode;
        int off;
        int exp_ticks;
        int exp_gain;
        bit exp_mode;
    } row_t;

    exp_t plan[$];
    int   idle_gain = 16;
    bit   idle_mode = 1'b0;
    bit   pop_pending = 1'b0;
    int   ph = 0;
    int   vectors = 0;
    int   fails = 0;

    task automatic check(string name, int act, int expv);
        vectors++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic fail_timeout(string name);
        vectors++;
        fails++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    function automatic int ref_step(int v, int t);
        if (v < t) return (t - v > STEP) ? v + STEP : t;
        if (v > t) return (v - t > STEP) ? v - STEP : t;
        return v;
    endfunction

    function automatic exp_t mk(int g, bit m, bit r, bit b);
        exp_t e;
        e.gain = g; e.mode = m; e.ready = r; e.busy = b;
        return e;
    endfunction

    function automatic exp_t now_exp();
        if (plan.size() > 0) return plan[0];
        return mk(idle_gain, idle_mode, 1'b1, 1'b0);
    endfunction

    function automatic bit model_ready();
        exp_t e = now_exp();
        return e.ready;
    endfunction

    task automatic push_slew(int from, int to, bit m, bit r);
        int v = from;
        while (v != to) begin
            plan.push_back(mk(v, m, r, 1'b1));
            v = ref_step(v, to);
        end
    endtask

    task automatic model_accept(int g, bit m);
        exp_t c = now_exp();
        plan.delete();
        pop_pending = 1'b0;
        if (m == c.mode) begin
            push_slew(c.gain, g, c.mode, 1'b1);
        end else begin
            push_slew(c.gain, 0, c.mode, 1'b0);
            repeat (SETTLE) plan.push_back(mk(0, m, 1'b0, 1'b1));
            push_slew(0, g, m, 1'b0);
        end
        idle_gain = g;
        idle_mode = m;
    endtask

    task automatic model_reset();
        plan.delete();
        pop_pending = 1'b0;
        push_slew(0, GAIN_ONE, 1'b0, 1'b0);
        idle_gain = GAIN_ONE;
        idle_mode = 1'b0;
    endtask

    task automatic check_model();
        exp_t e = now_exp();
        check("tick_gain",  int'(o_par_gain),  e.gain);
        check("tick_mode",  int'(o_ovrd_mode), int'(e.mode));
        check("tick_ready", int'(o_req_ready), int'(e.ready));
        check("tick_busy",  int'(o_busy),      int'(e.busy));
    endtask

    // One clock; inputs for the new cycle are set #1 after the edge.
    task automatic advance();
        @(posedge clk);
        #1;
        ph = (ph + 1) % 8;
        i_tick = (ph == 0);
        if (pop_pending) begin
            if (plan.size() > 0) plan.delete(0);
            pop_pending = 1'b0;
        end
        if (i_tick) begin
            check_model();
            pop_pending = 1'b1;
        end
    endtask

    task automatic wait_tick();
        do advance(); while (!i_tick);
    endtask

    task automatic issue(int g, bit m, int off);
        do advance(); while (ph != off);
        i_req_valid = 1'b1;
        i_req_gain  = 11'(g);
        i_req_mode  = m;
        check("req_ready", int'(o_req_ready), int'(model_ready()));
        model_accept(g, m);
        advance();
        i_req_valid = 1'b0;
    endtask

    task automatic drain(string name, int exp_ticks, int exp_gain, int exp_mode);
        int  k = 0;
        bit  done = 1'b0;
        while (!done && k <= 700) begin
            advance();
            if (i_tick) begin
                if (!o_busy) done = 1'b1;
                else k++;
            end
        end
        if (!done) fail_timeout({name, "_idle"});
        else begin
            if (exp_ticks >= 0) check({name, "_ticks"}, k, exp_ticks);
            check({name, "_gain"}, int'(o_par_gain), exp_gain);
            check({name, "_mode"}, int'(o_ovrd_mode), exp_mode);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        row_t rows[10];
        int   guard;

        rows[0] = '{18,  0, 3, 1,  18,  0};
        rows[1] = '{0,   0, 3, 5,  0,   0};
        rows[2] = '{16,  0, 3, 4,  16,  0};
        rows[3] = '{40,  1, 3, 18, 40,  1};
        rows[4] = '{20,  1, 3, 5,  20,  1};
        rows[5] = '{100, 1, 0, 20, 100, 1};
        rows[6] = '{7,   1, 3, 24, 7,   1};
        rows[7] = '{7,   1, 4, 0,  7,   1};
        rows[8] = '{0,   0, 5, 6,  0,   0};
        rows[9] = '{12,  1, 2, 7,  12,  1};

        // Reset and power-up fade-in to 1.0
        rst = 1'b0;
        repeat (3) advance();
        check("rst_gain",  int'(o_par_gain),  0);
        check("rst_mode",  int'(o_ovrd_mode), 0);
        check("rst_ready", int'(o_req_ready), 0);
        check("rst_busy",  int'(o_busy),      1);
        rst = 1'b1;
        model_reset();
        drain("powerup", 4, 16, 0);

        for (int i = 0; i < 10; i++) begin
            issue(rows[i].gain, rows[i].mode, rows[i].off);
            drain($sformatf("row%0d", i), rows[i].exp_ticks, rows[i].exp_gain, int'(rows[i].exp_mode));
        end

        // Retarget in the middle of an up-ramp
        issue(60, 1'b1, 3);
        repeat (3) wait_tick();
        issue(8, 1'b1, 4);
        drain("retarget", 4, 8, 1);

        // Reset while holding at zero after a swap to mode 1
        issue(30, 1'b0, 3);
        drain("to_mode0", 14, 30, 0);
        issue(40, 1'b1, 3);
        guard = 0;
        while (!(plan.size() > 0 && plan[0].gain == 0 && plan[0].mode && ph == 3) && guard < 300) begin
            advance();
            guard++;
        end
        if (guard >= 300) fail_timeout("reach_hold");
        check("hold_mode", int'(o_ovrd_mode), 1);
        rst = 1'b0;
        advance();
        rst = 1'b1;
        check("midrst_gain",  int'(o_par_gain),  0);
        check("midrst_mode",  int'(o_ovrd_mode), 0);
        check("midrst_ready", int'(o_req_ready), 0);
        check("midrst_busy",  int'(o_busy),      1);
        model_reset();
        drain("midrst", 4, 16, 0);

        // Request held through a mode swap, then ramp to full scale
        issue(2, 1'b1, 3);
        i_req_valid = 1'b1;
        i_req_gain  = 11'd2047;
        i_req_mode  = 1'b1;
        guard = 0;
        while (!(plan.size() == 0 && ph == 2) && guard < 400) begin
            advance();
            guard++;
        end
        if (guard >= 400) fail_timeout("held_req");
        check("held_ready", int'(o_req_ready), 1);
        model_accept(2047, 1'b1);
        advance();
        i_req_valid = 1'b0;
        drain("saturate", 512, 2047, 1);
        issue(2047, 1'b1, 4);
        drain("at_max", 0, 2047, 1);

        // Random requests, some issued while the sequencer is not ready
        for (int n = 0; n < 40; n++) begin
            int off = $urandom_range(2, 5);
            int w   = $urandom_range(0, 3);
            int g   = $urandom_range(0, 255);
            bit m   = ($urandom_range(0, 3) == 0) ? !idle_mode : idle_mode;
            repeat (w) wait_tick();
            if (model_ready()) begin
                issue(g, m, off);
            end else begin
                do advance(); while (ph != off);
                i_req_valid = 1'b1;
                i_req_gain  = 11'(g);
                i_req_mode  = m;
                check("busy_ready", int'(o_req_ready), 0);
                advance();
                i_req_valid = 1'b0;
            end
        end
        drain("random_end", -1, idle_gain, int'(idle_mode));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
